// File: rtl/drum_accum.sv
`default_nettype none
// ============================================================================
// Module   : drum_accum
// Purpose  : Streaming signed saturating accumulator placed after the drum
//            approximate multiplier. It sums a programmable number of products
//            per frame and presents the saturated frame total on a
//            valid/ready output port.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            len              - products per frame (0 means 2^CNT_W), sampled
//                               on the first beat of each frame
//            in_valid/in_ready/in_prod    - product input handshake
//            out_valid/out_ready/out_acc/out_sat - frame result handshake
// Revision : 1.0 - initial release
// ============================================================================
module drum_accum #(
  parameter int P_W   = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [P_W-1:0]          in_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_sat
);

  localparam logic [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W:0]          r_cnt;
  logic [CNT_W:0]          r_flen;
  logic                    r_sat;

  logic                    w_accept;
  logic                    w_first;
  logic [CNT_W:0]          w_len_ext;
  logic [CNT_W:0]          w_eff_len;
  logic [CNT_W:0]          w_cnt_inc;
  logic                    w_last;
  logic [ACC_W-1:0]        w_base;
  logic [ACC_W:0]          w_sum;
  logic                    w_pos_ovf;
  logic                    w_neg_ovf;
  logic [ACC_W-1:0]        w_clamped;
  logic                    w_sat_new;

  // A pending result only blocks input while the consumer is stalling it.
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  assign w_first   = (r_cnt == '0);
  assign w_len_ext = (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
  // On the first beat the frame length is the one being latched right now.
  assign w_eff_len = w_first ? w_len_ext : r_flen;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (w_cnt_inc == w_eff_len);

  // A new frame ignores whatever stale total is left in r_acc.
  assign w_base    = w_first ? '0 : r_acc;
  assign w_sum     = {w_base[ACC_W-1], w_base}
                   + {{(ACC_W+1-P_W){in_prod[P_W-1]}}, in_prod};

  // Sum of two ACC_W-range values always fits in ACC_W+1 bits, so overflow
  // shows up as disagreement between the top two bits.
  assign w_pos_ovf = !w_sum[ACC_W] &&  w_sum[ACC_W-1];
  assign w_neg_ovf =  w_sum[ACC_W] && !w_sum[ACC_W-1];

  always_comb begin
    w_clamped = w_sum[ACC_W-1:0];
    if (w_pos_ovf) begin
      w_clamped = C_ACC_MAX;
    end else if (w_neg_ovf) begin
      w_clamped = C_ACC_MIN;
    end
  end

  assign w_sat_new = (w_first ? 1'b0 : r_sat) | w_pos_ovf | w_neg_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_flen    <= '0;
      r_sat     <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_first) begin
          r_flen <= w_len_ext;
        end
        if (w_last) begin
          // Overrides the drain above so back-to-back results have no bubble.
          out_acc   <= w_clamped;
          out_sat   <= w_sat_new;
          out_valid <= 1'b1;
          r_cnt     <= '0;
        end else begin
          r_acc <= w_clamped;
          r_sat <= w_sat_new;
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_drum_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_drum_accum
// Purpose  : Self-checking bench for drum_accum. Two instances share one
//            stimulus stream: a 24-bit accumulator and an 18-bit one (the
//            narrow one makes saturation reachable). A frame-level model
//            predicts handshake behaviour and results for both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drum_accum;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        len = 8'd1;
  logic              in_valid = 1'b0;
  logic [15:0]       in_prod = '0;
  logic              out_ready = 1'b1;

  logic              in_ready0, in_ready1;
  logic              ov0, ov1;
  logic signed [23:0] acc0;
  logic signed [17:0] acc1;
  logic              sat0, sat1;

  drum_accum #(.P_W(16), .ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .len(len),
    .in_valid(in_valid), .in_ready(in_ready0), .in_prod(in_prod),
    .out_valid(ov0), .out_ready(out_ready), .out_acc(acc0), .out_sat(sat0)
  );

  drum_accum #(.P_W(16), .ACC_W(18), .CNT_W(8)) dut_s (
    .clk(clk), .rst(rst), .len(len),
    .in_valid(in_valid), .in_ready(in_ready1), .in_prod(in_prod),
    .out_valid(ov1), .out_ready(out_ready), .out_acc(acc1), .out_sat(sat1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit     mv = 1'b0;
  int     mcnt = 0;
  int     mlen = 0;
  longint mout[2]  = '{0, 0};
  bit     mosat[2] = '{0, 0};
  longint fsum[2]  = '{0, 0};
  bit     fsat[2]  = '{0, 0};
  longint lim_hi[2] = '{64'sd8388607, 64'sd131071};
  longint lim_lo[2] = '{-64'sd8388608, -64'sd131072};

  always @(posedge clk) begin : model
    bit acc_ok;
    longint t;
    if (rst) begin
      mv = 1'b0; mcnt = 0; mlen = 0;
      for (int k = 0; k < 2; k++) begin
        mout[k] = 0; mosat[k] = 1'b0; fsum[k] = 0; fsat[k] = 1'b0;
      end
    end else begin
      acc_ok = in_valid && (!mv || out_ready);
      if (mv && out_ready) mv = 1'b0;
      if (acc_ok) begin
        if (mcnt == 0) begin
          mlen = (len == 0) ? 256 : int'(len);
          for (int k = 0; k < 2; k++) begin fsum[k] = 0; fsat[k] = 1'b0; end
        end
        for (int k = 0; k < 2; k++) begin
          t = fsum[k] + longint'($signed(in_prod));
          if (t > lim_hi[k]) begin t = lim_hi[k]; fsat[k] = 1'b1; end
          if (t < lim_lo[k]) begin t = lim_lo[k]; fsat[k] = 1'b1; end
          fsum[k] = t;
        end
        mcnt++;
        if (mcnt == mlen) begin
          mv = 1'b1; mcnt = 0;
          for (int k = 0; k < 2; k++) begin mout[k] = fsum[k]; mosat[k] = fsat[k]; end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_in_ready0", in_ready0, (!mv || out_ready));
      chk("cmp_in_ready1", in_ready1, (!mv || out_ready));
      chk("cmp_out_valid0", ov0, mv);
      chk("cmp_out_valid1", ov1, mv);
      chk("cmp_out_acc0", acc0, mout[0]);
      chk("cmp_out_acc1", acc1, mout[1]);
      chk("cmp_out_sat0", sat0, mosat[0]);
      chk("cmp_out_sat1", sat1, mosat[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input logic [15:0] p);
    int n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    @(negedge clk);
    while (!in_ready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready=0 for %0d cycles expected 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    rst = 1'b1;
    @(posedge clk); #1;
    started = 1'b1;
    chk("reset_out_valid", ov0, 0);
    chk("reset_out_acc", acc0, 0);
    chk("reset_out_sat", sat0, 0);
    chk("reset_in_ready", in_ready0, 1);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Basic frame
    out_ready = 1'b1; len = 8'd4;
    beat(16'd3); beat(16'hFFFB); beat(16'd100); beat(16'h8000);
    chk("basic_valid", ov0, 1);
    chk("basic_acc", acc0, -32670);
    chk("basic_sat", sat0, 0);
    chk("basic_model_pin", mout[0], -32670);
    idle(2);

    // Length 0 means 256 beats
    len = 8'd0;
    for (int i = 0; i < 255; i++) beat(16'h7FFF);
    chk("len0_no_early_valid", ov0, 0);
    beat(16'h7FFF);
    chk("len0_acc", acc0, 8388352);
    chk("len0_sat", sat0, 0);
    chk("len0_acc_narrow", acc1, 131071);
    chk("len0_sat_narrow", sat1, 1);
    idle(2);

    // Saturation on the 18-bit instance
    len = 8'd5;
    for (int i = 0; i < 5; i++) beat(16'd32767);
    chk("satp_acc", acc1, 131071);
    chk("satp_sat", sat1, 1);
    chk("satp_acc_wide", acc0, 163835);
    chk("satp_model_pin", mout[1], 131071);
    for (int i = 0; i < 5; i++) beat(16'h8000);
    chk("satn_acc", acc1, -131072);
    chk("satn_sat", sat1, 1);
    chk("satn_acc_wide", acc0, -163840);
    len = 8'd2;
    beat(16'd1); beat(16'd1);
    chk("satclr_acc", acc1, 2);
    chk("satclr_sat", sat1, 0);
    idle(2);

    // Backpressure
    out_ready = 1'b0; len = 8'd2;
    beat(16'd1); beat(16'd2);
    chk("bp_acc", acc0, 3);
    chk("bp_in_ready", in_ready0, 0);
    in_valid = 1'b1; in_prod = 16'd3;
    idle(3);
    chk("bp_hold_acc", acc0, 3);
    chk("bp_hold_valid", ov0, 1);
    out_ready = 1'b1;
    beat(16'd3); beat(16'd4);
    chk("bp_resume_acc", acc0, 7);
    idle(2);

    // Back-to-back single-beat frames
    len = 8'd1;
    beat(16'd10);
    chk("b2b_acc_a", acc0, 10);
    beat(16'hFFFF);
    chk("b2b_valid_b", ov0, 1);
    chk("b2b_acc_b", acc0, -1);
    beat(16'd7);
    chk("b2b_acc_c", acc0, 7);
    idle(2);

    // Reset mid-frame
    len = 8'd3;
    beat(16'd5); beat(16'd5);
    rst = 1'b1; idle(1); rst = 1'b0;
    beat(16'd1); beat(16'd1);
    chk("rstmid_no_valid", ov0, 0);
    beat(16'd1);
    chk("rstmid_acc", acc0, 3);
    idle(2);

    // len change mid-frame
    len = 8'd3;
    beat(16'd2);
    len = 8'd1;
    beat(16'd2);
    chk("lenchg_no_valid", ov0, 0);
    beat(16'd2);
    chk("lenchg_acc", acc0, 6);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 3));
      in_prod   = (r == 0) ? 16'h7FFF : (r == 1) ? 16'h8000 : 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      len       = ($urandom_range(0, 63) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      rst       = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
